// File: rtl/fir_out_decimator.sv
`default_nettype none
// ============================================================================
// fir_out_decimator : FIR output rescale (round-half-up), saturate, decimate,
//                     and buffer kept samples in a valid/ready output FIFO.
// Revision: 1.0
// ============================================================================
module fir_out_decimator #(
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 4,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUM_W = IN_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] ROUND   = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(DECIM - 1);
  localparam logic [LVL_W-1:0]        LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 stg_valid_q, stg_valid_d;
  logic [OUT_WIDTH-1:0] stg_data_q, stg_data_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shifted;
  logic                    w_clamp_hi, w_clamp_lo, w_keep;
  logic                    w_pop, w_full, w_push;

  always_comb begin
    // One extra bit of headroom keeps the rounding add from wrapping.
    w_sum      = $signed({in_data[IN_WIDTH-1], in_data}) + ROUND;
    w_shifted  = w_sum >>> SHIFT;
    w_clamp_hi = (w_shifted > OUT_MAX);
    w_clamp_lo = (w_shifted < OUT_MIN);
    w_keep     = in_valid && (phase_q == '0);

    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    stg_valid_d = w_keep;
    stg_data_d  = stg_data_q;
    sat_d       = sat_q;
    if (w_keep) begin
      if (w_clamp_hi) begin
        stg_data_d = OUT_MAX[OUT_WIDTH-1:0];
      end else if (w_clamp_lo) begin
        stg_data_d = OUT_MIN[OUT_WIDTH-1:0];
      end else begin
        stg_data_d = w_shifted[OUT_WIDTH-1:0];
      end
      sat_d = sat_q | w_clamp_hi | w_clamp_lo;
    end

    // A pop frees the slot the incoming push needs when the FIFO is full.
    w_pop  = out_valid_q && out_ready;
    w_full = (level_q == LVL_FULL);
    w_push = stg_valid_q && (!w_full || w_pop);
    ovf_d  = ovf_q | (stg_valid_q && w_full && !w_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = stg_data_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    level_d = level_q;
    if (w_push && !w_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      level_d = level_q - LVL_W'(1);
    end

    // The head is registered; it keeps its last value once the FIFO drains.
    out_valid_d = (level_d != '0);
    out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= '0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;
  assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_decimator.sv
`default_nettype none
// ============================================================================
// tb_fir_out_decimator : two instances (DECIM=1 and DECIM=4) against a queue
//                        model; directed test-plan scenarios plus random traffic.
// Revision: 1.0
// ============================================================================
module tb_fir_out_decimator;

  localparam int IW = 18;
  localparam int OW = 8;
  localparam int SH = 4;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          out_ready;

  logic          ov1, sat1, ovf1, ov4, sat4, ovf4;
  logic [OW-1:0] od1, od4;
  logic [LW-1:0] lvl1, lvl4;

  fir_out_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(1), .FIFO_DEPTH(FD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .sat_flag(sat1), .ovf_flag(ovf1), .fifo_level(lvl1));

  fir_out_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(4), .FIFO_DEPTH(FD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .sat_flag(sat4), .ovf_flag(ovf4), .fifo_level(lvl4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Spec arithmetic: floor((x + 2^(SH-1)) / 2^SH), then clamp to OW bits.
  function automatic longint raw_scale(input longint x);
    return (x + (longint'(1) << (SH-1))) >>> SH;
  endfunction

  function automatic bit clamps(input longint x);
    longint r;
    r = raw_scale(x);
    return (r > 127) || (r < -128);
  endfunction

  function automatic longint rescale(input longint x);
    longint r;
    r = raw_scale(x);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic int dec_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Model state, index 0 = DECIM 1, index 1 = DECIM 4.
  int     m_cnt [2];
  bit     m_stv [2];
  longint m_stval [2];
  longint m_q [2][FD];
  int     m_n [2];
  longint m_out [2];
  bit     m_sat [2];
  bit     m_ovf [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_stv[i] = 0; m_stval[i] = 0; m_n[i] = 0;
        m_out[i] = 0; m_sat[i] = 0; m_ovf[i] = 0;
      end else begin
        if (m_n[i] > 0 && out_ready) begin
          for (int k = 0; k < FD-1; k++) m_q[i][k] = m_q[i][k+1];
          m_n[i]--;
        end
        if (m_stv[i]) begin
          if (m_n[i] < FD) begin
            m_q[i][m_n[i]] = m_stval[i];
            m_n[i]++;
          end else begin
            m_ovf[i] = 1;
          end
        end
        if (m_n[i] > 0) m_out[i] = m_q[i][0];
        m_stv[i] = in_valid && ((m_cnt[i] % dec_of(i)) == 0);
        if (m_stv[i]) begin
          m_stval[i] = rescale(longint'($signed(in_data)));
          if (clamps(longint'($signed(in_data)))) m_sat[i] = 1;
        end
        if (in_valid) m_cnt[i]++;
      end
    end
  end

  bit     cmp_en = 0;
  bit     cap_en = 0;
  longint cap1[$];
  longint cap4[$];

  task automatic cmp_one(input int i, input logic ov, input logic [OW-1:0] od,
                         input logic sat, input logic ovf, input logic [LW-1:0] lvl);
    string s;
    s = (i == 0) ? "d1" : "d4";
    chk({s, "_out_valid"}, longint'(ov), longint'(m_n[i] > 0));
    chk({s, "_fifo_level"}, longint'(lvl), longint'(m_n[i]));
    chk({s, "_out_data"}, longint'($signed(od)), m_out[i]);
    chk({s, "_sat_flag"}, longint'(sat), longint'(m_sat[i]));
    chk({s, "_ovf_flag"}, longint'(ovf), longint'(m_ovf[i]));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_one(0, ov1, od1, sat1, ovf1, lvl1);
      cmp_one(1, ov4, od4, sat4, ovf4, lvl4);
    end
    if (cap_en && out_ready) begin
      if (ov1) cap1.push_back(longint'($signed(od1)));
      if (ov4) cap4.push_back(longint'($signed(od4)));
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step(input bit v, input longint d, input bit rdy);
    in_valid  = v;
    in_data   = IW'(d);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(1, longint'($urandom_range(0, 262143)) - 131072, 0);
    step(1, longint'($urandom_range(0, 262143)) - 131072, 0);
    rst_n = 1;
  endtask

  task automatic chk_cap(input string nm, input longint got[$], input longint exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk($sformatf("%s_%0d", nm, k), got[k], exp[k]);
  endtask

  initial begin
    longint e[$];
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;

    chk("model_rescale_40", rescale(40), 3);
    chk("model_rescale_m24", rescale(-24), -1);
    chk("model_rescale_m25", rescale(-25), -2);
    chk("model_rescale_8", rescale(8), 1);
    chk("model_rescale_m8", rescale(-8), 0);
    chk("model_rescale_5000", rescale(5000), 127);
    chk("model_rescale_m5000", rescale(-5000), -128);

    do_reset();
    cmp_en = 1;
    chk("rst_d1_out_valid", ov1, 0);
    chk("rst_d1_level", lvl1, 0);
    chk("rst_d1_sat", sat1, 0);
    chk("rst_d1_ovf", ovf1, 0);
    chk("rst_d4_out_valid", ov4, 0);
    chk("rst_d4_level", lvl4, 0);

    // Rounding
    step(1, 40, 1);
    step(1, -24, 1);
    chk("round_d1_first", $signed(od1), 3);
    chk("round_d4_first_kept", $signed(od4), 3);
    step(1, -25, 1);
    step(1, 8, 1);
    step(1, -8, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("round_d1_sat_clear", sat1, 0);

    // Saturation
    step(1, 5000, 1);
    chk("sat_d1_flag_rise", sat1, 1);
    step(1, -5000, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("sat_d4_unkept_clear", sat4, 0);

    // Decimation with an in_valid gap
    do_reset();
    cap1.delete(); cap4.delete();
    cap_en = 1;
    for (int k = 0; k < 12; k++) begin
      step(1, 16 * k, 1);
      if (k == 5) begin step(0, 0, 1); step(0, 0, 1); end
    end
    for (int k = 0; k < 4; k++) step(0, 0, 1);
    cap_en = 0;
    e = '{0, 4, 8};
    chk_cap("decim_d4", cap4, e);

    // Full FIFO and overflow
    do_reset();
    cap1.delete(); cap4.delete();
    for (int k = 0; k < 6; k++) step(1, 16 * (k + 1), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    chk("ovf_d1_level", lvl1, 4);
    chk("ovf_d1_flag", ovf1, 1);
    chk("ovf_d4_level", lvl4, 2);
    chk("ovf_d4_flag", ovf4, 0);
    cap_en = 1;
    for (int k = 0; k < 6; k++) step(0, 0, 1);
    cap_en = 0;
    e = '{1, 2, 3, 4};
    chk_cap("drain_d1", cap1, e);
    e = '{1, 5};
    chk_cap("drain_d4", cap4, e);

    // Full FIFO with a simultaneous pop
    do_reset();
    cap1.delete(); cap4.delete();
    for (int k = 0; k < 4; k++) step(1, 16 * (k + 1), 0);
    step(0, 0, 0);
    step(1, 80, 0);
    chk("fullpop_d1_level_pre", lvl1, 4);
    cap_en = 1;
    for (int k = 0; k < 4; k++) begin
      step(1, 16 * (k + 6), 1);
      chk($sformatf("fullpop_d1_level_%0d", k), lvl1, 4);
      chk($sformatf("fullpop_d1_ovf_%0d", k), ovf1, 0);
    end
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    cap_en = 0;
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    chk_cap("fullpop_d1", cap1, e);

    // Random traffic with alternating back-pressure regimes
    do_reset();
    for (int c = 0; c < 600; c++) begin
      longint d;
      bit rdy;
      if ($urandom_range(0, 1) == 0) d = longint'($urandom_range(0, 4095)) - 2048;
      else d = longint'($urandom_range(0, 262143)) - 131072;
      if (((c / 60) % 3) == 2) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      if (c == 300) rst_n = 0;
      if (c == 302) rst_n = 1;
      step($urandom_range(0, 3) != 0, d, rdy);
    end
    step(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
